md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 33 +++
 rtl/md_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes issued by the
// control unit and the unit's sequencing states.
`timescale 1ns/1ps
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_SHL   = 4'd9
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_SHL);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide/shift unit owning the architectural HI/LO pair.
// Long ops latch operands at issue and commit HI/LO on the final RUN edge.
`timescale 1ns/1ps
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1) + 1;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        res;
    logic               res_we;
    logic               div_ovf;
    logic signed [31:0] div_num;
    logic signed [31:0] div_den;
    logic signed [31:0] div_quo;
    logic signed [31:0] div_rem;
    logic [31:0]        divu_den;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Zero and overflow divisors are swapped for 1 so the operator never traps;
    // with a 0x80000000 / -1 dividend that substitution already yields the
    // required LO=0x80000000, HI=0.
    always_comb begin
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        div_num  = a_q;
        div_den  = ((b_q == '0) || div_ovf) ? 32'sd1 : b_q;
        divu_den = (b_q == '0) ? 32'd1 : b_q;
        div_quo  = div_num / div_den;
        div_rem  = div_num % div_den;
        prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
    end

    // HI/LO cannot change during RUN, so the live pair equals the pair at issue.
    always_comb begin
        res    = '0;
        res_we = 1'b0;
        case (op_q)
            MD_MULT: begin
                res    = prod_s;
                res_we = 1'b1;
            end
            MD_MULTU: begin
                res    = prod_u;
                res_we = 1'b1;
            end
            MD_DIV: begin
                res    = {div_rem, div_quo};
                res_we = (b_q != '0);
            end
            MD_DIVU: begin
                res    = {a_q % divu_den, a_q / divu_den};
                res_we = (b_q != '0);
            end
            MD_SHL: begin
                res    = {hi_q, lo_q} << a_q[4:0];
                res_we = 1'b1;
            end
            default: begin
                res    = '0;
                res_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        state_d = ST_RUN;
                        op_d    = md_op_e'(md_op);
                        a_d     = rs_val;
                        b_d     = rt_val;
                        cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    end else if (md_op == MD_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (res_we) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_RUN) || (start && is_long_op(md_op));
        md_out = '0;
        if (md_op == MD_MFHI) begin
            md_out = hi_q;
        end else if (md_op == MD_MFLO) begin
            md_out = lo_q;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
